// File: rtl/store_verdict_monitor.sv
// Store-bus responder: turns the core's stores into a pass/fail/timeout verdict
// held until reset, and logs accepted stores in a FIFO drained over valid/ready.
module store_verdict_monitor #(
  parameter logic [31:0] PASS_ADDR      = 32'd100,
  parameter logic [31:0] PASS_DATA      = 32'd25,
  parameter logic [31:0] SCRATCH_ADDR   = 32'd96,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned LOG_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [31:0] cycle_count,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_overflow
);

  localparam int unsigned     PTR_W      = $clog2(LOG_DEPTH);
  localparam logic [31:0]     LAST_CYCLE = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W:0]  FULL_CNT   = (PTR_W + 1)'(LOG_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  fail_q, fail_d;
  logic [31:0] cycle_q;

  // NOTE: sequential state is assigned with <= only, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
      fail_q  <= 2'd0;
      cycle_q <= 32'd0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      if (state_q == ST_RUN) cycle_q <= cycle_q + 32'd1;
    end
  end

  // NOTE: defaults first, so every path assigns every signal and no latch forms.
  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    if (state_q == ST_RUN) begin
      if (MemWrite && DataAdr == PASS_ADDR) begin
        if (WriteData == PASS_DATA) begin
          state_d = ST_PASS;
        end else begin
          state_d = ST_FAIL;
          fail_d  = 2'd2;
        end
      end else if (MemWrite && DataAdr != SCRATCH_ADDR) begin
        state_d = ST_FAIL;
        fail_d  = 2'd1;
      end else if (cycle_q == LAST_CYCLE) begin
        // A verdict store on this edge took precedence above.
        state_d = ST_TIMEOUT;
      end
    end
  end

  always_comb begin
    done      = (state_q != ST_RUN);
    pass      = (state_q == ST_PASS);
    fail_code = 2'd0;
    case (state_q)
      ST_FAIL:    fail_code = fail_q;
      ST_TIMEOUT: fail_code = 2'd3;
      default:    fail_code = 2'd0;
    endcase
  end

  assign cycle_count = cycle_q;

  logic [31:0]      mem_addr [LOG_DEPTH];
  logic [31:0]      mem_data [LOG_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             ovf_q;
  logic             push, pop, full, accept;

  assign log_valid = (count != '0);
  assign full      = (count == FULL_CNT);
  assign push      = (state_q == ST_RUN) && MemWrite;
  assign pop       = log_valid && log_ready;
  assign accept    = push && (!full || pop);

  // NOTE: the storage array has no reset; only pointers and count define which
  // entries are live, and the head is masked while the log is empty.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_addr[wr_ptr] <= DataAdr;
      mem_data[wr_ptr] <= WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign log_addr     = log_valid ? mem_addr[rd_ptr] : 32'd0;
  assign log_data     = log_valid ? mem_data[rd_ptr] : 32'd0;
  assign log_overflow = ovf_q;

endmodule

// File: tb/tb_store_verdict_monitor.sv
// Bench for store_verdict_monitor: directed test-plan scenarios plus random
// store traffic, all checked every cycle against a queue-based verdict model.
module tb_store_verdict_monitor;

  localparam int unsigned TO    = 16;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic        log_ready = 1'b0;
  logic        done, pass, log_valid, log_overflow;
  logic [1:0]  fail_code;
  logic [31:0] cycle_count, log_addr, log_data;

  store_verdict_monitor #(
    .PASS_ADDR(32'd100), .PASS_DATA(32'd25), .SCRATCH_ADDR(32'd96),
    .TIMEOUT_CYCLES(TO), .LOG_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .done(done), .pass(pass), .fail_code(fail_code),
    .cycle_count(cycle_count), .log_valid(log_valid), .log_ready(log_ready),
    .log_addr(log_addr), .log_data(log_data), .log_overflow(log_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } entry_t;

  entry_t      m_q[$];
  logic [31:0] m_done, m_pass, m_code, m_cycles, m_ovf;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: verdict rules applied to one rising edge with the sampled inputs.
  task automatic model_edge(input logic rst, input logic mw, input logic [31:0] a,
                            input logic [31:0] d, input logic rdy);
    entry_t e;
    if (!rst) begin
      m_q.delete();
      m_done = 0; m_pass = 0; m_code = 0; m_cycles = 0; m_ovf = 0;
    end else begin
      if (m_q.size() != 0 && rdy) e = m_q.pop_front();
      if (m_done == 0) begin
        m_cycles++;
        if (mw && a == 32'd100) begin
          m_done = 1;
          if (d == 32'd25) m_pass = 1; else m_code = 2;
        end else if (mw && a != 32'd96) begin
          m_done = 1; m_code = 1;
        end else if (m_cycles == TO) begin
          m_done = 1; m_code = 3;
        end
        if (mw) begin
          if (m_q.size() < DEPTH) begin
            e.a = a; e.d = d;
            m_q.push_back(e);
          end else begin
            m_ovf = 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("done", {31'd0, done}, m_done);
    check("pass", {31'd0, pass}, m_pass);
    check("fail_code", {30'd0, fail_code}, m_code);
    check("cycle_count", cycle_count, m_cycles);
    check("log_valid", {31'd0, log_valid}, (m_q.size() != 0) ? 32'd1 : 32'd0);
    check("log_overflow", {31'd0, log_overflow}, m_ovf);
    if (m_q.size() != 0) begin
      check("log_addr", log_addr, m_q[0].a);
      check("log_data", log_data, m_q[0].d);
    end
  endtask

  task automatic step(input logic rst, input logic mw, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy);
    reset = rst; MemWrite = mw; DataAdr = a; WriteData = d; log_ready = rdy;
    @(posedge clk);
    model_edge(rst, mw, a, d, rdy);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input logic rdy);
    step(1'b1, 1'b0, $urandom, $urandom, rdy);
  endtask

  task automatic do_reset();
    step(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    do_reset();
    do_reset();

    // Pass path, then drain both entries.
    step(1'b1, 1'b1, 32'd96, 32'd7, 1'b0);
    step(1'b1, 1'b1, 32'd100, 32'd25, 1'b0);
    check("pass_done", {31'd0, done}, 32'd1);
    check("pass_head", log_data, 32'd7);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Wrong data; a later good store is ignored.
    do_reset();
    step(1'b1, 1'b1, 32'd100, 32'd24, 1'b0);
    step(1'b1, 1'b1, 32'd100, 32'd25, 1'b0);
    check("wrong_data_code", {30'd0, fail_code}, 32'd2);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Illegal address after some scratch traffic; counter freezes.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'd96, $urandom, 1'($urandom_range(0, 1)));
    step(1'b1, 1'b1, 32'd104, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'($urandom_range(0, 1)));
    check("illegal_frozen", cycle_count, 32'd5);

    // Pure timeout.
    do_reset();
    for (int i = 0; i < 20; i++) idle(1'($urandom_range(0, 1)));
    check("timeout_count", cycle_count, 32'd16);

    // Scratch store on the timeout edge: timeout still fires.
    do_reset();
    for (int i = 0; i < 15; i++) idle(1'b0);
    step(1'b1, 1'b1, 32'd96, 32'd1, 1'b0);
    check("timeout_scratch", {30'd0, fail_code}, 32'd3);
    for (int i = 0; i < 2; i++) idle(1'b1);

    // Pass store on the timeout edge wins.
    do_reset();
    for (int i = 0; i < 15; i++) idle(1'b0);
    step(1'b1, 1'b1, 32'd100, 32'd25, 1'b0);
    check("timeout_pass", {31'd0, pass}, 32'd1);

    // Overflow: nine stores into an eight-entry log, then drain.
    do_reset();
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b1, 32'd96, 32'(i), 1'b0);
    for (int i = 0; i < 9; i++) idle(1'b1);

    // Full log with simultaneous push and pop: no overflow, still eight entries.
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 32'd96, 32'(i + 20), 1'b0);
    step(1'b1, 1'b1, 32'd96, 32'd99, 1'b1);
    check("full_pushpop_ovf", {31'd0, log_overflow}, 32'd0);
    for (int i = 0; i < 9; i++) idle(1'b1);

    // Reset mid-run discards the log, then a pass store still works.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'd96, $urandom, 1'b0);
    do_reset();
    check("midreset_valid", {31'd0, log_valid}, 32'd0);
    step(1'b1, 1'b1, 32'd100, 32'd25, 1'b0);

    // Random traffic with occasional resets.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int i = 0; i < 30; i++) begin
        int unsigned k;
        logic        rdy;
        k   = $urandom_range(0, 39);
        rdy = 1'($urandom_range(0, 1));
        if (k == 0)       do_reset();
        else if (k == 1)  step(1'b1, 1'b1, 32'd100, ($urandom_range(0, 1) != 0) ? 32'd25 : $urandom, rdy);
        else if (k == 2)  step(1'b1, 1'b1, $urandom, $urandom, rdy);
        else if (k < 20)  step(1'b1, 1'b1, 32'd96, $urandom, rdy);
        else              idle(rdy);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
